// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the clk_div_bank divider bank.
//   DEF_DIV      : reset half-period length (clk cycles) of every channel
//   MAX_CNT_W    : storage width of the per-channel counter/divide fields;
//                  CNT_W of the bank must not exceed it
//   chan_state_t : per-channel divider state {cnt, div, s_clk}
//   ch_idx_w()   : width of a channel index, never less than one bit
// -----------------------------------------------------------------------------
package clk_div_pkg;

   localparam int unsigned DEF_DIV   = 500_000;
   localparam int unsigned MAX_CNT_W = 32;

   typedef struct packed {
      logic [MAX_CNT_W-1:0] cnt;
      logic [MAX_CNT_W-1:0] div;
      logic                 s_clk;
   } chan_state_t;

   function automatic int unsigned ch_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
// One divider channel: half-period counter, s_clk toggle, rising-edge tick and
// the divide register, which is loaded from apply_div_i when apply_i is high.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   en_i         : run enable; low forces cnt=0 and s_clk=0
//   apply_i      : load apply_div_i into the divide register this cycle
//   apply_div_i  : new half-period length (0 = stopped)
//   running_o    : channel is enabled with a non-zero divide value
//   boundary_o   : this cycle ends a half-period (s_clk toggles at the edge)
//   s_clk_o      : divided clock, registered
//   tick_o       : one-cycle pulse registered together with each s_clk rise
//
// Build option: CLK_DIV_TICK_EN enables the tick register; without it tick_o
// is tied low and s_clk behaviour is unchanged.
// -----------------------------------------------------------------------------
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W       = 26,
   parameter int unsigned DEF_DIV_VAL = clk_div_pkg::DEF_DIV
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             apply_i,
   input  logic [CNT_W-1:0] apply_div_i,
   output logic             running_o,
   output logic             boundary_o,
   output logic             s_clk_o,
   output logic             tick_o
);

   localparam logic [MAX_CNT_W-1:0] ONE       = MAX_CNT_W'(1);
   localparam logic [MAX_CNT_W-1:0] RESET_DIV = MAX_CNT_W'(CNT_W'(DEF_DIV_VAL));

   chan_state_t st_q, st_d;
   logic        running;
   logic        boundary;

   assign running  = en_i && (st_q.div != '0);
   assign boundary = running && (st_q.cnt == (st_q.div - ONE));

   always_comb begin
      st_d = st_q;
      if (!en_i) begin
         st_d.cnt   = '0;
         st_d.s_clk = 1'b0;
      end else if (st_q.div == '0) begin
         // stopped: level frozen, counter parked
         st_d.cnt = '0;
      end else if (boundary) begin
         st_d.cnt   = '0;
         st_d.s_clk = ~st_q.s_clk;
      end else begin
         st_d.cnt = st_q.cnt + ONE;
      end
      // On a running channel apply_i only arrives on a boundary, so the toggle
      // above still used the old div and the next half-period uses the new one.
      if (apply_i) begin
         st_d.div = MAX_CNT_W'(apply_div_i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q <= '{cnt: '0, div: RESET_DIV, s_clk: 1'b0};
      end else begin
         st_q <= st_d;
      end
   end

`ifdef CLK_DIV_TICK_EN
   logic tick_q, tick_d;

   // a boundary while s_clk is low is the 0->1 toggle
   assign tick_d = boundary && !st_q.s_clk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q <= 1'b0;
      end else begin
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;
`else
   assign tick_o = 1'b0;
`endif

   assign running_o  = running;
   assign boundary_o = boundary;
   assign s_clk_o    = st_q.s_clk;

endmodule

// File: rtl/clk_div_bank.sv
// -----------------------------------------------------------------------------
// clk_div_bank
// Bank of NUM_CH independent 50%-duty clock dividers with a shared valid/ready
// configuration port. An accepted value sits in a single shadow slot until the
// target channel can take it glitch-free: at its next half-period boundary if
// running, or in the following cycle if it is disabled or stopped (div=0).
//
// Valid/ready: a config transfer happens on any rising clk edge where
// cfg_valid && cfg_ready. cfg_ready is low exactly while the shadow slot is
// occupied; cfg_valid may be held or dropped freely.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : per-channel run enable
//   cfg_valid   : config request
//   cfg_ready   : shadow slot free
//   cfg_sel     : target channel; out-of-range values are accepted and dropped
//   cfg_div     : new half-period length in clk cycles (0 = stop)
//   s_clk       : divided clocks, registered
//   tick        : one-cycle pulse with each s_clk rise
//
// Build option: CLK_DIV_TICK_EN enables tick generation (tick=0 otherwise).
// -----------------------------------------------------------------------------
module clk_div_bank #(
   parameter int unsigned NUM_CH  = 2,
   parameter int unsigned CNT_W   = 26,
   parameter int unsigned DEF_DIV = clk_div_pkg::DEF_DIV
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic [NUM_CH-1:0]                          en,
   input  logic                                       cfg_valid,
   output logic                                       cfg_ready,
   input  logic [clk_div_pkg::ch_idx_w(NUM_CH)-1:0]   cfg_sel,
   input  logic [CNT_W-1:0]                           cfg_div,
   output logic [NUM_CH-1:0]                          s_clk,
   output logic [NUM_CH-1:0]                          tick
);

   import clk_div_pkg::*;

   localparam int unsigned      SEL_W    = ch_idx_w(NUM_CH);
   localparam logic [SEL_W:0]   NUM_CH_L = (SEL_W+1)'(NUM_CH);

   logic              pending_q, pending_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [CNT_W-1:0]  div_q, div_d;

   logic              accept;
   logic              sel_ok;
   logic [NUM_CH-1:0] apply;
   logic [NUM_CH-1:0] running;
   logic [NUM_CH-1:0] boundary;

   assign cfg_ready = !pending_q;
   assign accept    = cfg_valid && !pending_q;
   assign sel_ok    = {1'b0, cfg_sel} < NUM_CH_L;

   // A running target waits for its boundary; an idle one takes it at once.
   always_comb begin
      apply = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (pending_q && (sel_q == SEL_W'(i)) && (!running[i] || boundary[i])) begin
            apply[i] = 1'b1;
         end
      end
   end

   always_comb begin
      pending_d = pending_q;
      sel_d     = sel_q;
      div_d     = div_q;
      if (accept && sel_ok) begin
         pending_d = 1'b1;
         sel_d     = cfg_sel;
         div_d     = cfg_div;
      end else if (|apply) begin
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= 1'b0;
         sel_q     <= '0;
         div_q     <= '0;
      end else begin
         pending_q <= pending_d;
         sel_q     <= sel_d;
         div_q     <= div_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      clk_div_chan #(
         .CNT_W       (CNT_W),
         .DEF_DIV_VAL (DEF_DIV)
      ) u_chan (
         .clk         (clk),
         .rst_n       (rst_n),
         .en_i        (en[g]),
         .apply_i     (apply[g]),
         .apply_div_i (div_q),
         .running_o   (running[g]),
         .boundary_o  (boundary[g]),
         .s_clk_o     (s_clk[g]),
         .tick_o      (tick[g])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// -----------------------------------------------------------------------------
// tb_clk_div_bank
// Bench for clk_div_bank with NUM_CH=3, CNT_W=8, DEF_DIV=4. Each scenario task
// pushes the expected {cfg_ready, tick[2:0], s_clk[2:0]} word for every cycle
// onto exp_q as it drives the inputs, then pops and compares after the edge.
// Expected waveforms come from the closed form: n cycles after a channel
// starts from cnt=0, s_clk = (n/div) odd, and tick marks n % (2*div) == div.
// -----------------------------------------------------------------------------
module tb_clk_div_bank;

   localparam int NUM_CH  = 3;
   localparam int CNT_W   = 8;
   localparam int DEF_DIV = 4;
   localparam int W       = 1 + 2*NUM_CH;

`ifdef CLK_DIV_TICK_EN
   localparam bit TICK_ON = 1'b1;
`else
   localparam bit TICK_ON = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic              clk;
   logic              rst_n;
   logic [NUM_CH-1:0] en;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [1:0]        cfg_sel;
   logic [CNT_W-1:0]  cfg_div;
   logic [NUM_CH-1:0] s_clk;
   logic [NUM_CH-1:0] tick;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   clk_div_bank #(
      .NUM_CH  (NUM_CH),
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_sel   (cfg_sel),
      .cfg_div   (cfg_div),
      .s_clk     (s_clk),
      .tick      (tick)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   logic [W-1:0] got;
   logic [W-1:0] exp;
   int           checks   = 0;
   int           failures = 0;

   function automatic logic sq(input int n, input int d);
      return ((n / d) % 2) == 1;
   endfunction

   function automatic logic rise(input int n, input int d);
      return (n > 0) && ((n % (2*d)) == d);
   endfunction

   function automatic logic [W-1:0] mk(input logic r, input logic [2:0] t, input logic [2:0] s);
      return {r, t & {3{TICK_ON}}, s};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0; en = '0; cfg_valid = 1'b0; cfg_sel = '0; cfg_div = '0;
      repeat (3) @(posedge clk);
      #1;
      en = 3'b111;
      exp_q.push_back(mk(1'b1, 3'b000, 3'b000));
      step();
      got = {cfg_ready, tick, s_clk}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL reset_held got=%b exp=%b", got, exp); end
      @(negedge clk);
      rst_n = 1'b1;
      en = '0;
      exp_q.push_back(mk(1'b1, 3'b000, 3'b000));
      step();
      got = {cfg_ready, tick, s_clk}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL reset_idle got=%b exp=%b", got, exp); end
   endtask

   task automatic test_default_div();
      en = 3'b111;
      for (int n = 1; n <= 24; n++) begin
         exp_q.push_back(mk(1'b1, {3{rise(n, DEF_DIV)}}, {3{sq(n, DEF_DIV)}}));
         step();
         got = {cfg_ready, tick, s_clk}; exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin failures++; $display("FAIL default_div n=%0d got=%b exp=%b", n, got, exp); end
      end
   endtask

   task automatic test_reprogram_running();
      // load ch0 with 10 while disabled
      en = '0; cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_div = 8'd10;
      exp_q.push_back(mk(1'b0, 3'b000, 3'b000));
      exp_q.push_back(mk(1'b1, 3'b000, 3'b000));
      for (int k = 0; k < 2; k++) begin
         step();
         cfg_valid = 1'b0;
         got = {cfg_ready, tick, s_clk}; exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin failures++; $display("FAIL reprog_load k=%0d got=%b exp=%b", k, got, exp); end
      end
      en = 3'b001;
      // write 3 mid-way through the second half-period; it lands at n=20
      for (int n = 1; n <= 38; n++) begin
         cfg_valid = (n == 16);
         cfg_div   = 8'd3;
         if (n <= 20) begin
            exp_q.push_back(mk(!(n >= 16 && n <= 19), {2'b00, rise(n, 10)}, {2'b00, sq(n, 10)}));
         end else begin
            exp_q.push_back(mk(1'b1, {2'b00, rise(n - 20, 3)}, {2'b00, sq(n - 20, 3)}));
         end
         step();
         got = {cfg_ready, tick, s_clk}; exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin failures++; $display("FAIL reprog_run n=%0d got=%b exp=%b", n, got, exp); end
      end
   endtask

   task automatic test_disabled_write();
      en = '0; cfg_valid = 1'b1; cfg_sel = 2'd1; cfg_div = 8'd5;
      exp_q.push_back(mk(1'b0, 3'b000, 3'b000));
      exp_q.push_back(mk(1'b1, 3'b000, 3'b000));
      for (int k = 0; k < 2; k++) begin
         step();
         cfg_valid = 1'b0;
         got = {cfg_ready, tick, s_clk}; exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin failures++; $display("FAIL dis_write k=%0d got=%b exp=%b", k, got, exp); end
      end
      en = 3'b010;
      for (int n = 1; n <= 12; n++) begin
         exp_q.push_back(mk(1'b1, {1'b0, rise(n, 5), 1'b0}, {1'b0, sq(n, 5), 1'b0}));
         step();
         got = {cfg_ready, tick, s_clk}; exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin failures++; $display("FAIL dis_run n=%0d got=%b exp=%b", n, got, exp); end
      end
   endtask

   // continues ch1 (div=5) from n=12 of test_disabled_write
   task automatic test_stop_resume();
      logic s, t, r;
      cfg_sel = 2'd1;
      for (int n = 13; n <= 37; n++) begin
         cfg_valid = (n == 13) || (n == 24);
         cfg_div   = (n < 20) ? 8'd0 : 8'd2;
         if (n <= 15) begin
            s = sq(n, 5); t = rise(n, 5);
         end else if (n <= 25) begin
            s = 1'b1; t = 1'b0;
         end else begin
            s = ~sq(n - 25, 2); t = ((n - 25) % 4) == 0;
         end
         r = !((n == 13) || (n == 14) || (n == 24));
         exp_q.push_back(mk(r, {1'b0, t, 1'b0}, {1'b0, s, 1'b0}));
         step();
         got = {cfg_ready, tick, s_clk}; exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin failures++; $display("FAIL stop_resume n=%0d got=%b exp=%b", n, got, exp); end
      end
      cfg_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      en = '0; cfg_sel = 2'd0;
      // accepts land on k=0,2,4 (div 2,4,6); k=5 (div 7) meets cfg_ready=0
      for (int k = 0; k < 6; k++) begin
         cfg_valid = 1'b1;
         cfg_div   = 8'(k + 2);
         exp_q.push_back(mk((k % 2) == 1, 3'b000, 3'b000));
         step();
         got = {cfg_ready, tick, s_clk}; exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin failures++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, got, exp); end
      end
      cfg_valid = 1'b0;
      en = 3'b001;
      for (int n = 1; n <= 14; n++) begin
         exp_q.push_back(mk(1'b1, {2'b00, rise(n, 6)}, {2'b00, sq(n, 6)}));
         step();
         got = {cfg_ready, tick, s_clk}; exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin failures++; $display("FAIL b2b_run n=%0d got=%b exp=%b", n, got, exp); end
      end
   endtask

   // ch0 div=6; enable drops on the boundary that would raise s_clk (n=18)
   task automatic test_en_fall_boundary();
      en = '0;
      exp_q.push_back(mk(1'b1, 3'b000, 3'b000));
      step();
      got = {cfg_ready, tick, s_clk}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL enfall_idle got=%b exp=%b", got, exp); end
      for (int n = 1; n <= 21; n++) begin
         en = (n < 18) ? 3'b001 : 3'b000;
         if (n < 18) exp_q.push_back(mk(1'b1, {2'b00, rise(n, 6)}, {2'b00, sq(n, 6)}));
         else        exp_q.push_back(mk(1'b1, 3'b000, 3'b000));
         step();
         got = {cfg_ready, tick, s_clk}; exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin failures++; $display("FAIL enfall n=%0d got=%b exp=%b", n, got, exp); end
      end
   endtask

   task automatic test_reset_pending();
      for (int n = 1; n <= 8; n++) begin
         en = 3'b001; cfg_valid = (n == 7); cfg_sel = 2'd0; cfg_div = 8'd9;
         exp_q.push_back(mk(n < 7, {2'b00, rise(n, 6)}, {2'b00, sq(n, 6)}));
         step();
         got = {cfg_ready, tick, s_clk}; exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin failures++; $display("FAIL rstpend_run n=%0d got=%b exp=%b", n, got, exp); end
      end
      cfg_valid = 1'b0;
      // asynchronous reset mid-cycle with s_clk[0]=1 and a config pending
      #2;
      rst_n = 1'b0;
      exp_q.push_back(mk(1'b1, 3'b000, 3'b000));
      #1;
      got = {cfg_ready, tick, s_clk}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL rstpend_async got=%b exp=%b", got, exp); end
      @(negedge clk);
      rst_n = 1'b1;
      en = 3'b111;
      // every divider back at DEF_DIV
      for (int n = 1; n <= 16; n++) begin
         exp_q.push_back(mk(1'b1, {3{rise(n, DEF_DIV)}}, {3{sq(n, DEF_DIV)}}));
         step();
         got = {cfg_ready, tick, s_clk}; exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin failures++; $display("FAIL rstpend_def n=%0d got=%b exp=%b", n, got, exp); end
      end
   endtask

   task automatic test_bad_sel();
      en = '0;
      exp_q.push_back(mk(1'b1, 3'b000, 3'b000));
      step();
      got = {cfg_ready, tick, s_clk}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL badsel_idle got=%b exp=%b", got, exp); end
      for (int n = 1; n <= 16; n++) begin
         en = 3'b111; cfg_valid = (n == 5) || (n == 6); cfg_sel = 2'd3; cfg_div = 8'd1;
         exp_q.push_back(mk(1'b1, {3{rise(n, DEF_DIV)}}, {3{sq(n, DEF_DIV)}}));
         step();
         got = {cfg_ready, tick, s_clk}; exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin failures++; $display("FAIL badsel n=%0d got=%b exp=%b", n, got, exp); end
      end
      cfg_valid = 1'b0;
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_default_div();
      test_reprogram_running();
      test_disabled_write();
      test_stop_resume();
      test_back_to_back();
      test_en_fall_boundary();
      test_reset_pending();
      test_bad_sel();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain left=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
